// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side; slave is the subtractor.
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus borrow register, LSB first,
// WIDTH clocks per operation. diff/bout update only when the last bit is processed.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             x, y, d_bit, br_nx;

  // Full-subtractor cell on the current LSBs of the shifting operands
  assign x     = a_q[0];
  assign y     = b_q[0];
  assign d_bit = x ^ y ^ br_q;
  assign br_nx = (~x & y) | (~(x ^ y) & br_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        sr_d  = {d_bit, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the completed word straight from the shift path
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          diff_d  = {d_bit, sr_q[WIDTH-1:1]};
          bout_d  = br_nx;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): latency, results, hold behaviour,
// start masking, mid-op reset and back-to-back operation.
module tb_serial_sub;
  localparam int W = 8;

  logic clk, rst;
  int   n_chk, n_fail;
  logic [W-1:0] prev_diff;
  logic         prev_bout;

  serial_sub_if #(.WIDTH(W)) bus();
  serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input bit glitch);
    int cyc, bcnt, extra;
    bit seen;
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1; bcnt = 0; seen = 0;
    while (cyc <= 40 && !seen) begin
      chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 0);
      if (bus.done) seen = 1;
      else begin
        if (bus.busy) bcnt++;
        if (cyc == 5) begin
          chk("hold_diff", bus.diff, prev_diff);
          chk("hold_bout", bus.bout, prev_bout);
        end
        if (glitch && cyc == 3) begin
          bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.bin = 1'b1;
        end
        if (glitch && cyc == 4) bus.start = 1'b0;
        tick();
        cyc++;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", cyc, W + 1);
    chk("busy_cycles", bcnt, W);
    chk("diff", bus.diff, ed);
    chk("bout", bus.bout, eb);
    prev_diff = ed;
    prev_bout = eb;
    tick();
    chk("done_one_cycle", bus.done, 0);
    if (glitch) begin
      extra = 0;
      for (int i = 0; i < 15; i++) begin
        if (bus.done) extra++;
        tick();
      end
      chk("glitch_extra_done", extra, 0);
      chk("glitch_diff_kept", bus.diff, ed);
    end
  endtask

  initial begin
    int cyc, last, ndone, extra;
    logic [8:0] q[$];
    logic [8:0] e;
    logic [W-1:0] ra, rb;
    logic rbin;

    n_chk = 0; n_fail = 0;
    prev_diff = '0; prev_bout = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1);

    // Reset during the 4th RUN cycle
    bus.a = 8'h20; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_diff", bus.diff, 0);
    chk("abort_bout", bus.bout, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) extra++;
      tick();
    end
    chk("abort_no_done", extra, 0);
    prev_diff = '0; prev_bout = 1'b0;
    run_op(8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0, 0);

    // Back-to-back with start held high
    ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
    bus.a = ra; bus.b = rb; bus.bin = rbin;
    q.push_back({1'b0, ra} - {1'b0, rb} - {8'd0, rbin});
    bus.start = 1'b1;
    cyc = 0; last = -1; ndone = 0;
    while (ndone < 5 && cyc < 200) begin
      tick();
      cyc++;
      chk("b2b_excl", {31'd0, bus.busy & bus.done}, 0);
      if (bus.done) begin
        e = q.pop_front();
        chk("b2b_diff", bus.diff, e[W-1:0]);
        chk("b2b_bout", bus.bout, e[W]);
        if (last >= 0) chk("b2b_spacing", cyc - last, W + 2);
        last = cyc;
        ndone++;
        ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
        bus.a = ra; bus.b = rb; bus.bin = rbin;
        q.push_back({1'b0, ra} - {1'b0, rb} - {8'd0, rbin});
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", ndone, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
